// File: rtl/io_fifo_port.sv
// io_fifo_port: memory-mapped I/O peripheral with a CPU-fed TX FIFO and a
// producer-fed RX FIFO behind a 4-word register window.
//   offset 0 DATA   : read pops RX head, write pushes TX
//   offset 1 STATUS : {rx_count, 0, irq_en, rx_underflow, tx_overflow,
//                      tx_full, tx_empty, rx_full, rx_empty}
//   offset 2 CTRL   : bit0 clear sticky flags, bit1 flush FIFOs, bit2 irq_en
//   offset 3        : unmapped, never drives the bus
// Optional feature macro: IO_IRQ_EN adds the registered irq output and makes
// CTRL bit2 writable. Without it irq_en is tied to 0 and there is no irq port.
module io_fifo_port #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'hF0,
    parameter int                    DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
`ifdef IO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int             PW       = $clog2(DEPTH);
    localparam int             CW       = PW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem_d [DEPTH];

    logic [PW-1:0] rx_wptr_q, rx_wptr_d;
    logic [PW-1:0] rx_rptr_q, rx_rptr_d;
    logic [CW-1:0] rx_count_q, rx_count_d;
    logic [PW-1:0] tx_wptr_q, tx_wptr_d;
    logic [PW-1:0] tx_rptr_q, tx_rptr_d;
    logic [CW-1:0] tx_count_q, tx_count_d;

    logic tx_ovf_q, tx_ovf_d;
    logic rx_udf_q, rx_udf_d;
    logic irq_en_q, irq_en_d;

    // ------------------------------------------------------------------
    // Decode and flags
    // ------------------------------------------------------------------
    logic                  hit;
    logic [1:0]            offset;
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic                  data_rd;
    logic                  data_wr;
    logic                  ctrl_wr;
    logic                  flush;
    logic                  clr_sticky;
    logic [DATA_WIDTH-1:0] wr_data;

    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_push, rx_pop, tx_push, tx_pop;

    logic                  bus_drive;
    logic [DATA_WIDTH-1:0] rd_data;

    assign rx_empty = (rx_count_q == '0);
    assign rx_full  = (rx_count_q == FULL_CNT);
    assign tx_empty = (tx_count_q == '0);
    assign tx_full  = (tx_count_q == FULL_CNT);

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? '0 : tx_mem_q[tx_rptr_q];

    // Address decode, strobe qualification and handshake events.
    // A simultaneous read+write is treated as a write only.
    always_comb begin
        hit        = (bus_addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
        offset     = bus_addr[1:0];
        wr_data    = bus_data;
        cpu_wr     = write && hit;
        cpu_rd     = read && !write && hit;
        data_rd    = cpu_rd && (offset == 2'd0);
        data_wr    = cpu_wr && (offset == 2'd0);
        ctrl_wr    = cpu_wr && (offset == 2'd2);
        flush      = ctrl_wr && wr_data[1];
        clr_sticky = ctrl_wr && wr_data[0];
        bus_drive  = cpu_rd && (offset != 2'd3);

        // Flush wins over every push and pop on both FIFOs.
        rx_push    = rx_valid && rx_ready && !flush;
        rx_pop     = data_rd && !rx_empty && !flush;
        tx_push    = data_wr && !tx_full && !flush;
        tx_pop     = tx_valid && tx_ready && !flush;
    end

    // Read data mux for the register window.
    always_comb begin
        rd_data = '0;
        case (offset)
            2'd0: begin
                if (!rx_empty) begin
                    rd_data = rx_mem_q[rx_rptr_q];
                end
            end
            2'd1: begin
                rd_data[0]       = rx_empty;
                rd_data[1]       = rx_full;
                rd_data[2]       = tx_empty;
                rd_data[3]       = tx_full;
                rd_data[4]       = tx_ovf_q;
                rd_data[5]       = rx_udf_q;
                rd_data[6]       = irq_en_q;
                rd_data[8 +: CW] = rx_count_q;
            end
            2'd2: begin
                rd_data[2] = irq_en_q;
            end
            default: rd_data = '0;
        endcase
    end

    assign bus_data = bus_drive ? rd_data : 'z;

    // ------------------------------------------------------------------
    // RX FIFO next state
    // ------------------------------------------------------------------
    // RX storage write from the producer.
    always_comb begin
        rx_mem_d = rx_mem_q;
        if (rx_push) begin
            rx_mem_d[rx_wptr_q] = rx_data;
        end
    end

    // RX pointers and occupancy.
    always_comb begin
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_count_d = rx_count_q;
        if (flush) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_count_d = '0;
        end else begin
            if (rx_push) begin
                rx_wptr_d = rx_wptr_q + PW'(1);
            end
            if (rx_pop) begin
                rx_rptr_d = rx_rptr_q + PW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count_d = rx_count_q + CW'(1);
                2'b01:   rx_count_d = rx_count_q - CW'(1);
                default: rx_count_d = rx_count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO next state
    // ------------------------------------------------------------------
    // TX storage write from the CPU.
    always_comb begin
        tx_mem_d = tx_mem_q;
        if (tx_push) begin
            tx_mem_d[tx_wptr_q] = wr_data;
        end
    end

    // TX pointers and occupancy.
    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_count_d = tx_count_q;
        if (flush) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_count_d = '0;
        end else begin
            if (tx_push) begin
                tx_wptr_d = tx_wptr_q + PW'(1);
            end
            if (tx_pop) begin
                tx_rptr_d = tx_rptr_q + PW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count_d = tx_count_q + CW'(1);
                2'b01:   tx_count_d = tx_count_q - CW'(1);
                default: tx_count_d = tx_count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags and interrupt enable
    // ------------------------------------------------------------------
    // Sets come from DATA accesses, clears from CTRL writes, so they never
    // collide in one cycle.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_udf_d = rx_udf_q;
        if (clr_sticky) begin
            tx_ovf_d = 1'b0;
            rx_udf_d = 1'b0;
        end
        if (data_wr && tx_full) begin
            tx_ovf_d = 1'b1;
        end
        if (data_rd && rx_empty) begin
            rx_udf_d = 1'b1;
        end
`ifdef IO_IRQ_EN
        irq_en_d = ctrl_wr ? wr_data[2] : irq_en_q;
`else
        irq_en_d = 1'b0;
`endif
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_udf_q   <= rx_udf_d;
            irq_en_q   <= irq_en_d;
        end
    end

    // FIFO storage; contents are qualified by the counts, so no reset needed.
    always_ff @(posedge clk) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end

`ifdef IO_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt is registered from current state, one cycle behind it.
    always_comb begin
        irq_d = irq_en_q && (!rx_empty || tx_ovf_q || rx_udf_q);
    end

    // Interrupt output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_io_fifo_port.sv
// Scoreboard bench for io_fifo_port: stimulus queues expected bus-read and
// TX-consumer values; monitors pop and compare when the DUT presents them.
module tb_io_fifo_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bus_addr;
    wire  [15:0] bus_data;
    logic        read;
    logic        write;
    logic [15:0] rx_data;
    logic        rx_valid;
    wire         rx_ready;
    wire  [15:0] tx_data;
    wire         tx_valid;
    logic        tx_ready;
`ifdef IO_IRQ_EN
    wire         irq;
    localparam logic [15:0] IEN = 16'h0040;
`else
    localparam logic [15:0] IEN = 16'h0000;
`endif

    logic [15:0] cpu_wdata;
    logic        cpu_drive;
    assign bus_data = cpu_drive ? cpu_wdata : 'z;

    always #5 clk = ~clk;

    io_fifo_port #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8),
        .BASE_ADDR (8'hF0),
        .DEPTH     (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus_addr(bus_addr),
        .bus_data(bus_data),
        .read    (read),
        .write   (write),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
`ifdef IO_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_bus_q [$];
    string       exp_bus_nm [$];
    logic [15:0] exp_tx_q [$];

    logic [15:0] mon_v;
    string       mon_n;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Bus monitor: a driven read of the window consumes one expectation.
    always @(negedge clk) begin
        if (!reset && read && !write && bus_addr[7:2] == 6'h3C && bus_addr[1:0] != 2'd3) begin
            if (exp_bus_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL bus_unexpected: got %h expected no read", bus_data);
            end else begin
                mon_v = exp_bus_q.pop_front();
                mon_n = exp_bus_nm.pop_front();
                check(mon_n, bus_data, mon_v);
            end
        end
        if (!reset && tx_valid && tx_ready) begin
            if (exp_tx_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL tx_unexpected: got %h expected no transfer", tx_data);
            end else begin
                mon_v = exp_tx_q.pop_front();
                check("tx_out", tx_data, mon_v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] e, input string nm);
        bus_addr = a;
        read     = 1'b1;
        exp_bus_q.push_back(e);
        exp_bus_nm.push_back(nm);
        tick();
        read = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        bus_addr  = a;
        cpu_wdata = d;
        cpu_drive = 1'b1;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        cpu_drive = 1'b0;
    endtask

    task automatic push_rx(input logic [15:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        cpu_drive = 1'b0;
        cpu_wdata = '0;
        bus_addr  = '0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_rx_ready", {15'd0, rx_ready}, 16'd1);
        check("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
        check("rst_tx_data", tx_data, 16'h0000);
        rd(8'hF1, 16'h0005, "status_reset");
        rd(8'hF2, 16'h0000, "ctrl_reset");

        // RX path and underflow
        push_rx(16'h1111);
        push_rx(16'h2222);
        rd(8'hF1, 16'h0204, "status_rx2");
        rd(8'hF0, 16'h1111, "rx_pop1");
        rd(8'hF0, 16'h2222, "rx_pop2");
        rd(8'hF0, 16'h0000, "rx_underflow_data");
        rd(8'hF1, 16'h0025, "status_underflow");
        wr(8'hF2, 16'h0001);
        rd(8'hF1, 16'h0005, "status_cleared");

        // TX fill, overflow, drain in order
        for (int i = 1; i <= 5; i++) wr(8'hF0, 16'hA000 + 16'(i));
        rd(8'hF1, 16'h0019, "status_tx_full");
        check("tx_valid_full", {15'd0, tx_valid}, 16'd1);
        check("tx_head", tx_data, 16'hA001);
        for (int i = 1; i <= 4; i++) exp_tx_q.push_back(16'hA000 + 16'(i));
        tx_ready = 1'b1;
        repeat (4) tick();
        tx_ready = 1'b0;
        check("tx_valid_drained", {15'd0, tx_valid}, 16'd0);
        rd(8'hF1, 16'h0015, "status_tx_ovf");
        wr(8'hF2, 16'h0001);
        rd(8'hF1, 16'h0005, "status_cleared2");

        // RX full, pop with producer waiting, pointer wrap
        for (int i = 1; i <= 4; i++) push_rx(16'hB000 + 16'(i));
        check("rx_ready_full", {15'd0, rx_ready}, 16'd0);
        rd(8'hF1, 16'h0406, "status_rx_full");
        rx_data  = 16'hB005;
        rx_valid = 1'b1;
        rd(8'hF0, 16'hB001, "rx_pop_full");
        check("rx_ready_after_pop", {15'd0, rx_ready}, 16'd1);
        rd(8'hF1, 16'h0304, "status_cnt3");
        rx_valid = 1'b0;
        rd(8'hF1, 16'h0406, "status_refull");
        for (int i = 2; i <= 5; i++) rd(8'hF0, 16'hB000 + 16'(i), "rx_wrap_order");
        rd(8'hF1, 16'h0005, "status_rx_empty");

        // Same-cycle RX push and pop
        push_rx(16'hF001);
        rx_data  = 16'hF002;
        rx_valid = 1'b1;
        rd(8'hF0, 16'hF001, "rx_pushpop_data");
        rx_valid = 1'b0;
        rd(8'hF1, 16'h0104, "status_pushpop_cnt");
        rd(8'hF0, 16'hF002, "rx_pushpop_second");

        // Flush overrides a same-cycle producer push
        push_rx(16'hC001);
        push_rx(16'hC002);
        wr(8'hF0, 16'hD001);
        wr(8'hF0, 16'hD002);
        rd(8'hF1, 16'h0200, "status_both_data");
        rx_data  = 16'hC003;
        rx_valid = 1'b1;
        wr(8'hF2, 16'h0002);
        rx_valid = 1'b0;
        check("flush_tx_valid", {15'd0, tx_valid}, 16'd0);
        check("flush_tx_data", tx_data, 16'h0000);
        check("flush_rx_ready", {15'd0, rx_ready}, 16'd1);
        rd(8'hF1, 16'h0005, "status_flushed");
        rd(8'hF0, 16'h0000, "flush_discard");
        rd(8'hF1, 16'h0025, "status_flush_udf");
        push_rx(16'hE001);
        wr(8'hF2, 16'h0003);
        rd(8'hF1, 16'h0005, "status_clear_flush");

        // Read+write together performs the write only; ignored writes
        bus_addr  = 8'hF0;
        cpu_wdata = 16'h7777;
        cpu_drive = 1'b1;
        write     = 1'b1;
        read      = 1'b1;
        tick();
        read      = 1'b0;
        write     = 1'b0;
        cpu_drive = 1'b0;
        wr(8'hF3, 16'h0002);
        wr(8'hE2, 16'h0002);
        wr(8'hF1, 16'h00FF);
        rd(8'hF1, 16'h0001, "status_rw_write");
        check("rw_tx_head", tx_data, 16'h7777);
        exp_tx_q.push_back(16'h7777);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("rw_tx_drained", {15'd0, tx_valid}, 16'd0);

        // Interrupt enable bit
        wr(8'hF2, 16'h0004);
        rd(8'hF2, IEN >> 4, "ctrl_irq_en");
        rd(8'hF1, 16'h0005 | IEN, "status_irq_en");
`ifdef IO_IRQ_EN
        check("irq_idle", {15'd0, irq}, 16'd0);
        push_rx(16'h9999);
        check("irq_lag", {15'd0, irq}, 16'd0);
        tick();
        check("irq_set", {15'd0, irq}, 16'd1);
        rd(8'hF0, 16'h9999, "irq_pop");
        check("irq_hold", {15'd0, irq}, 16'd1);
        tick();
        check("irq_clear", {15'd0, irq}, 16'd0);
`endif

        // Reset in the middle of traffic
        push_rx(16'h1234);
        wr(8'hF0, 16'h4321);
        rx_data  = 16'h5555;
        rx_valid = 1'b1;
        reset    = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        rx_valid = 1'b0;
        check("mid_rst_rx_ready", {15'd0, rx_ready}, 16'd1);
        check("mid_rst_tx_valid", {15'd0, tx_valid}, 16'd0);
        check("mid_rst_tx_data", tx_data, 16'h0000);
`ifdef IO_IRQ_EN
        check("mid_rst_irq", {15'd0, irq}, 16'd0);
`endif
        rd(8'hF1, 16'h0005, "status_mid_rst");
        rd(8'hF2, 16'h0000, "ctrl_mid_rst");

        repeat (3) tick();
        if (exp_bus_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL bus_pending: got %0d outstanding expected 0", exp_bus_q.size());
        end
        if (exp_tx_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_pending: got %0d outstanding expected 0", exp_tx_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
